// File: rtl/led_matrix_scanner.sv
// Double-buffered LED matrix row scanner.
// Frames enter a shadow buffer and swap in at frame boundaries.
module led_matrix_scanner #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int DWELL          = 2,
  parameter int BLANK          = 0,
  parameter int ROW_ACTIVE_LOW = 1,
  parameter int BR_W           = 2
) (
  input  logic                  clka,
  input  logic                  restart,
  input  logic [ROWS*COLS-1:0]  frame_in,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [BR_W-1:0]       brightness,
  output logic [ROWS-1:0]       row_cathode,
  output logic [COLS-1:0]       column_anode,
  output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] row_index,
  output logic                  frame_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] B_LAST =
    BW'((BLANK > 0) ? BLANK - 1 : 0);

  localparam logic IDLE_BIT = (ROW_ACTIVE_LOW != 0);
  localparam logic [ROWS-1:0] ROW_IDLE = {ROWS{IDLE_BIT}};

  typedef enum logic [1:0] {
    S_START,
    S_DRIVE,
    S_BLANK
  } state_t;

  state_t          state, state_n;
  logic [RW-1:0]   row, row_n;
  logic [DW-1:0]   dwell, dwell_n;
  logic [BW-1:0]   bcnt, bcnt_n;

  logic [ROWS*COLS-1:0] active;
  logic [ROWS*COLS-1:0] shadow;
  logic                 pending;
  logic [BR_W-1:0]      br_lat;

  logic            xfer;
  logic            last_row;
  logic            row_end;
  logic [RW-1:0]   row_wrap;
  logic [ROWS-1:0] row_sel;
  logic            lit;

  assign xfer     = frame_valid && !pending;
  assign last_row = (row == R_LAST);
  assign row_end  = (dwell == D_LAST);
  assign row_wrap = last_row ? '0 : row + 1'b1;

  // Scan state register; reset parks in START.
  always_ff @(posedge clka) begin
    if (restart) begin
      state <= S_START;
      row   <= '0;
      dwell <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      dwell <= dwell_n;
      bcnt  <= bcnt_n;
    end
  end

  // Next scan position: dwell, optional blank, next row.
  always_comb begin
    state_n = state;
    row_n   = row;
    dwell_n = dwell;
    bcnt_n  = bcnt;
    unique case (state)
      S_START: begin
        state_n = S_DRIVE;
        row_n   = '0;
        dwell_n = '0;
        bcnt_n  = '0;
      end
      S_DRIVE: begin
        if (row_end) begin
          dwell_n = '0;
          if (BLANK > 0) begin
            state_n = S_BLANK;
            bcnt_n  = '0;
          end else begin
            row_n = row_wrap;
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      S_BLANK: begin
        if (bcnt == B_LAST) begin
          bcnt_n  = '0;
          state_n = S_DRIVE;
          row_n   = row_wrap;
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end
      default: begin
        state_n = S_START;
        row_n   = '0;
        dwell_n = '0;
        bcnt_n  = '0;
      end
    endcase
  end

  // Last cycle of the last row closes the frame.
  always_comb begin
    frame_done = 1'b0;
    if (last_row) begin
      if (BLANK == 0) begin
        frame_done = (state == S_DRIVE) && row_end;
      end else begin
        frame_done = (state == S_BLANK) &&
                     (bcnt == B_LAST);
      end
    end
  end

  // Shadow capture, frame-boundary swap, brightness latch.
  always_ff @(posedge clka) begin
    if (restart) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      br_lat  <= '0;
    end else begin
      if (state == S_START || frame_done) begin
        br_lat <= brightness;
      end
      if (frame_done && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (xfer) begin
        shadow  <= frame_in;
        pending <= 1'b1;
      end
    end
  end

  assign row_sel = ROWS'(1) << row;
  assign lit     = (BR_W'(dwell) < br_lat);

  // Output decode from registered scan position.
  always_comb begin
    row_cathode  = ROW_IDLE;
    column_anode = '0;
    if (state == S_DRIVE) begin
      row_cathode = ROW_IDLE ^ row_sel;
      if (lit) begin
        column_anode = active[row*COLS +: COLS];
      end
    end
  end

  assign row_index   = row;
  assign frame_ready = !pending;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomized bench for led_matrix_scanner, two configurations.
// Reference model works from frame cycle count, not FSM states.
module tb_led_matrix_scanner;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic        restart;

  logic [63:0] fin0;
  logic        fv0, fr0, fd0;
  logic [1:0]  br0;
  logic [7:0]  rc0, ca0;
  logic [2:0]  ri0;

  logic [23:0] fin1;
  logic        fv1, fr1, fd1;
  logic [1:0]  br1;
  logic [3:0]  rc1;
  logic [5:0]  ca1;
  logic [1:0]  ri1;

  led_matrix_scanner u_dut0 (
    .clka         (clka),
    .restart      (restart),
    .frame_in     (fin0),
    .frame_valid  (fv0),
    .frame_ready  (fr0),
    .brightness   (br0),
    .row_cathode  (rc0),
    .column_anode (ca0),
    .row_index    (ri0),
    .frame_done   (fd0)
  );

  led_matrix_scanner #(
    .ROWS           (4),
    .COLS           (6),
    .DWELL          (3),
    .BLANK          (1),
    .ROW_ACTIVE_LOW (0),
    .BR_W           (2)
  ) u_dut1 (
    .clka         (clka),
    .restart      (restart),
    .frame_in     (fin1),
    .frame_valid  (fv1),
    .frame_ready  (fr1),
    .brightness   (br1),
    .row_cathode  (rc1),
    .column_anode (ca1),
    .row_index    (ri1),
    .frame_done   (fd1)
  );

  int c_rows [2] = '{8, 4};
  int c_cols [2] = '{8, 6};
  int c_dw   [2] = '{2, 3};
  int c_bl   [2] = '{0, 1};
  int c_al   [2] = '{1, 0};

  bit          m_start [2];
  int          m_t     [2];
  logic [63:0] m_act   [2];
  logic [63:0] m_sh    [2];
  bit          m_pend  [2];
  int          m_br    [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_check(int k, logic [63:0] rc,
                             logic [63:0] ca,
                             logic [63:0] ri,
                             logic [63:0] fd,
                             logic [63:0] fr);
    int per, row, ph;
    logic [63:0] ones, e_rc, e_ca, e_ri, e_fd;
    per  = c_dw[k] + c_bl[k];
    ones = (64'd1 << c_rows[k]) - 64'd1;
    e_rc = (c_al[k] != 0) ? ones : 64'd0;
    e_ca = 64'd0;
    e_ri = 64'd0;
    e_fd = 64'd0;
    if (!m_start[k]) begin
      row  = m_t[k] / per;
      ph   = m_t[k] % per;
      e_ri = 64'(row);
      e_fd = 64'(m_t[k] == c_rows[k] * per - 1);
      if (ph < c_dw[k]) begin
        e_rc = (c_al[k] != 0) ? (ones & ~(64'd1 << row))
                              : (64'd1 << row);
        if (ph < m_br[k])
          e_ca = (m_act[k] >> (row * c_cols[k])) &
                 ((64'd1 << c_cols[k]) - 64'd1);
      end
    end
    chk($sformatf("d%0d row_cathode", k), rc, e_rc);
    chk($sformatf("d%0d column_anode", k), ca, e_ca);
    chk($sformatf("d%0d row_index", k), ri, e_ri);
    chk($sformatf("d%0d frame_done", k), fd, e_fd);
    chk($sformatf("d%0d frame_ready", k), fr,
        64'(!m_pend[k]));
  endtask

  task automatic model_step(int k, bit rst, bit v,
                            logic [63:0] fin, int b);
    int  per;
    bit  xfer;
    per = c_dw[k] + c_bl[k];
    if (rst) begin
      m_start[k] = 1'b1;
      m_t[k]     = 0;
      m_act[k]   = 64'd0;
      m_sh[k]    = 64'd0;
      m_pend[k]  = 1'b0;
      m_br[k]    = 0;
      return;
    end
    xfer = v && !m_pend[k];
    if (m_start[k]) begin
      m_start[k] = 1'b0;
      m_t[k]     = 0;
      m_br[k]    = b;
    end else if (m_t[k] == c_rows[k] * per - 1) begin
      m_t[k]  = 0;
      m_br[k] = b;
      if (m_pend[k]) begin
        m_act[k]  = m_sh[k];
        m_pend[k] = 1'b0;
      end
    end else begin
      m_t[k]++;
    end
    if (xfer) begin
      m_sh[k]   = fin;
      m_pend[k] = 1'b1;
    end
  endtask

  initial begin
    restart = 1'b1;
    fv0  = 1'b0;
    fv1  = 1'b0;
    fin0 = '0;
    fin1 = '0;
    br0  = '0;
    br1  = '0;
    repeat (2) @(posedge clka);
    model_step(0, 1'b1, 1'b0, 64'd0, 0);
    model_step(1, 1'b1, 1'b0, 64'd0, 0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clka);
      model_check(0, 64'(rc0), 64'(ca0), 64'(ri0),
                  64'(fd0), 64'(fr0));
      model_check(1, 64'(rc1), 64'(ca1), 64'(ri1),
                  64'(fd1), 64'(fr1));
      restart = (cyc == 0) ||
                (cyc >= 2000 && cyc < 2002) ||
                ($urandom_range(0, 499) == 0);
      fv0  = ($urandom_range(0, 3) == 0);
      fv1  = ($urandom_range(0, 3) == 0);
      fin0 = {$urandom, $urandom};
      fin1 = 24'($urandom);
      br0  = 2'($urandom);
      br1  = 2'($urandom);
      model_step(0, restart, fv0, fin0, int'(br0));
      model_step(1, restart, fv1, {40'd0, fin1},
                 int'(br1));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
